mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a cache memory with repeat-write priming and timeout recovery
module mem_arbiter #(
  parameter int TIMEOUT = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [4:0] addr0,
  input  logic [4:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  output logic       grant_id,
  output logic [4:0] mem_address,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  input  logic [7:0] mem_q,
  input  logic       mem_valid
);
  typedef enum logic [1:0] {SETTLE, IDLE, ISSUE, WAIT} state_t;
  state_t state, state_d;
  logic prime, prime_d, grant_d, ack0_d, ack1_d, err_d, wren_d, last_wren, last_wren_d, seen, seen_d;
  logic [7:0] rdata_d, data_d;
  logic [4:0] addr_d, last_addr, last_addr_d;
  logic [5:0] cnt, cnt_d;
  logic elig0, elig1, pick, pick_we, repeat_wr;
  logic [4:0] pick_addr;
  logic [7:0] pick_data;
  assign elig0 = req0 && !ack0;
  assign elig1 = req1 && !ack1;
  assign pick = elig0 && elig1 ? !grant_id : elig1;
  assign pick_we = pick ? we1 : we0;
  assign pick_addr = pick ? addr1 : addr0;
  assign pick_data = pick ? wdata1 : wdata0;
  // the memory only restarts on an address/wren change, so a repeated write is primed by a read first
  assign repeat_wr = pick_we && pick_addr == last_addr && last_wren;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    prime_d = prime;
    grant_d = grant_id;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    err_d = 1'b0;
    rdata_d = rdata;
    addr_d = mem_address;
    data_d = mem_data;
    wren_d = mem_wren;
    cnt_d = cnt;
    last_addr_d = last_addr;
    last_wren_d = last_wren;
    seen_d = 1'b0;
    case (state)
      SETTLE: begin
        seen_d = mem_valid;
        if (mem_valid && seen) begin
          state_d = IDLE;
          last_addr_d = 5'd0;
          last_wren_d = 1'b0;
          seen_d = 1'b0;
        end
      end
      IDLE: if (elig0 || elig1) begin
        grant_d = pick;
        addr_d = pick_addr;
        data_d = pick_data;
        wren_d = pick_we && !repeat_wr;
        prime_d = repeat_wr;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = 6'd0;
        state_d = WAIT;
      end
      WAIT: if (mem_valid) begin
        if (prime) begin
          prime_d = 1'b0;
          wren_d = 1'b1;
          state_d = ISSUE;
        end else begin
          rdata_d = mem_q;
          ack0_d = !grant_id;
          ack1_d = grant_id;
          last_addr_d = mem_address;
          last_wren_d = mem_wren;
          state_d = IDLE;
        end
      end else if (cnt >= 6'(TIMEOUT)) begin
        ack0_d = !grant_id;
        ack1_d = grant_id;
        err_d = 1'b1;
        rdata_d = 8'h00;
        prime_d = 1'b0;
        addr_d = 5'd0;
        wren_d = 1'b0;
        state_d = SETTLE;
      end else begin
        cnt_d = cnt == 6'h3f ? cnt : cnt + 6'd1;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SETTLE;
      prime <= 1'b0;
      grant_id <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err <= 1'b0;
      rdata <= 8'h00;
      mem_address <= 5'd0;
      mem_data <= 8'h00;
      mem_wren <= 1'b0;
      cnt <= 6'd0;
      last_addr <= 5'd0;
      last_wren <= 1'b0;
      seen <= 1'b0;
    end else begin
      state <= state_d;
      prime <= prime_d;
      grant_id <= grant_d;
      ack0 <= ack0_d;
      ack1 <= ack1_d;
      err <= err_d;
      rdata <= rdata_d;
      mem_address <= addr_d;
      mem_data <= data_d;
      mem_wren <= wren_d;
      cnt <= cnt_d;
      last_addr <= last_addr_d;
      last_wren <= last_wren_d;
      seen <= seen_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural cache memory model
module tb_mem_arbiter;
  logic clock = 0, reset = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, err, busy, grant_id, mem_wren, mem_valid;
  logic [7:0] rdata, mem_data, mem_q;
  logic [4:0] mem_address;
  always #5 clock = ~clock;
  mem_arbiter #(.TIMEOUT(63)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy), .grant_id(grant_id),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .mem_valid(mem_valid)
  );
  typedef struct packed { logic port; logic [7:0] data; logic err; } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0, acks_seen = 0;
  // memory model: an op starts whenever {address, wren} changes and completes lat edges later
  logic [7:0] mem [32];
  logic [31:0] wr_mask = 0;
  logic [5:0] prev_key = 6'h3f;
  logic [7:0] q = 8'h00;
  logic mv = 0, stall = 0, chg, done;
  int lat = 0, cd = 0;
  function automatic logic [7:0] init_val(input logic [4:0] a);
    return a == 5'd0 ? 8'h05 : a == 5'd2 ? 8'h01 : 8'h10 + {3'b000, a};
  endfunction
  assign chg = {mem_address, mem_wren} != prev_key;
  assign done = chg ? lat == 0 : cd == 1;
  assign mem_valid = mv && !stall;
  assign mem_q = q;
  always @(posedge clock) begin
    if (chg) prev_key <= {mem_address, mem_wren};
    if (chg) mv <= 1'b0;
    cd <= chg ? lat : (cd > 0 ? cd - 1 : 0);
    if (done) begin
      mv <= 1'b1;
      q <= mem_wren ? mem_data : (wr_mask[mem_address] ? mem[mem_address] : init_val(mem_address));
      if (mem_wren) begin
        mem[mem_address] <= mem_data;
        wr_mask[mem_address] <= 1'b1;
      end
    end
  end
  always @(negedge clock) begin
    if (ack0 || ack1) begin
      acks_seen++;
      checks++;
      if (ack0 && ack1) begin
        errors++;
        $display("FAIL ack_overlap ack0=%b ack1=%b required only one high", ack0, ack1);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack port=%0d rdata=%h err=%b required no ack", ack1, rdata, err);
      end else begin
        e = sb.pop_front();
        if ({ack1, rdata, err} !== e) begin
          errors++;
          $display("FAIL ack_result port=%0d rdata=%h err=%b required port=%0d rdata=%h err=%b",
                   ack1, rdata, err, e.port, e.data, e.err);
        end
      end
    end
  end
  task automatic run_req(input logic p, input logic we, input logic [4:0] a, input logic [7:0] d,
                         output logic got, output logic idle_first, output logic first_wren, output int cyc);
    logic cap;
    @(posedge clock); #1;
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    got = 0; idle_first = 0; cap = 0; first_wren = 0; cyc = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = p ? ack1 : ack0;
      if (cap) cyc++;
      if (!got) begin
        if (!busy) idle_first = 1;
        else if (idle_first && !cap) begin cap = 1; first_wren = mem_wren; cyc = 1; end
      end
    end
    @(posedge clock); #1;
    if (p) req1 = 0; else req0 = 0;
  endtask
  task automatic do_reset;
    @(posedge clock); #1;
    reset = 1; req0 = 0; req1 = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    sb.delete();
  endtask
  task automatic test_reset;
    logic got, idl, fw;
    int cyc;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, grant_id} !== 2'b11) begin errors++; $display("FAIL reset_state busy=%b grant_id=%b required 1 1", busy, grant_id); end
    checks++;
    if ({ack0, ack1, err} !== 3'b000) begin errors++; $display("FAIL reset_acks ack0=%b ack1=%b err=%b required 0 0 0", ack0, ack1, err); end
    checks++;
    if ({rdata, mem_address, mem_data, mem_wren} !== 22'd0) begin
      errors++;
      $display("FAIL reset_regs rdata=%h addr=%h data=%h wren=%b required all zero", rdata, mem_address, mem_data, mem_wren);
    end
    @(posedge clock); #1 reset = 0;
    sb.push_back(exp_t'({1'b0, 8'h05, 1'b0}));
    run_req(0, 0, 5'd0, 8'h00, got, idl, fw, cyc);
    checks++;
    if (!got || !idl) begin errors++; $display("FAIL first_read acked=%b idle_before_ack=%b required 1 1", got, idl); end
  endtask
  task automatic test_dual;
    logic d0 = 0, d1 = 0, g0 = 1, g1 = 0, first = 1;
    do_reset();
    sb.push_back(exp_t'({1'b0, 8'h01, 1'b0}));
    sb.push_back(exp_t'({1'b1, 8'h05, 1'b0}));
    req0 = 1; we0 = 0; addr0 = 5'd2;
    req1 = 1; we1 = 0; addr1 = 5'd0;
    for (int i = 0; i < 100 && !(d0 && d1); i++) begin
      @(negedge clock);
      if (ack0) begin if (!d1) first = 0; d0 = 1; g0 = grant_id; end
      if (ack1) begin d1 = 1; g1 = grant_id; end
      @(posedge clock); #1;
      if (d0) req0 = 0;
      if (d1) req1 = 0;
    end
    checks++;
    if ({d0, d1, first} !== 3'b110) begin errors++; $display("FAIL dual_order ack0=%b ack1=%b first_port=%0d required 1 1 0", d0, d1, first); end
    checks++;
    if ({g0, g1} !== 2'b01) begin errors++; $display("FAIL dual_grant_id at_ack0=%b at_ack1=%b required 0 1", g0, g1); end
  endtask
  task automatic test_repeat_write;
    logic got, idl, fw;
    int cyc;
    sb.push_back(exp_t'({1'b0, 8'hA5, 1'b0}));
    run_req(0, 1, 5'd7, 8'hA5, got, idl, fw, cyc);
    checks++;
    if ({got, fw, cyc[3:0]} !== {2'b11, 4'd3}) begin errors++; $display("FAIL first_write acked=%b wren=%b cycles=%0d required 1 1 3", got, fw, cyc); end
    sb.push_back(exp_t'({1'b0, 8'h3C, 1'b0}));
    run_req(0, 1, 5'd7, 8'h3C, got, idl, fw, cyc);
    checks++;
    if ({got, fw, cyc[3:0]} !== {2'b10, 4'd5}) begin errors++; $display("FAIL primed_write acked=%b wren=%b cycles=%0d required 1 0 5", got, fw, cyc); end
    checks++;
    if (mem_wren !== 1'b1) begin errors++; $display("FAIL primed_wren_final wren=%b required 1", mem_wren); end
    sb.push_back(exp_t'({1'b0, 8'h3C, 1'b0}));
    run_req(0, 0, 5'd7, 8'h00, got, idl, fw, cyc);
    checks++;
    if ({got, cyc[3:0]} !== {1'b1, 4'd3}) begin errors++; $display("FAIL readback acked=%b cycles=%0d required 1 3", got, cyc); end
  endtask
  task automatic test_back_to_back;
    logic [4:0] at [3] = '{5'd3, 5'd5, 5'd3};
    logic [7:0] dt [3] = '{8'h13, 8'h15, 8'h13};
    logic got;
    int base = acks_seen;
    @(posedge clock); #1;
    req1 = 1; we1 = 0; addr1 = at[0];
    sb.push_back(exp_t'({1'b1, dt[0], 1'b0}));
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin @(negedge clock); got = ack1; end
      checks++;
      if (!got) begin errors++; $display("FAIL b2b_ack idx=%0d acked=0 required 1", k); end
      @(posedge clock); #1;
      if (k < 2) begin addr1 = at[k+1]; sb.push_back(exp_t'({1'b1, dt[k+1], 1'b0})); end
      else req1 = 0;
      @(negedge clock);
      checks++;
      if (ack1 !== 1'b0) begin errors++; $display("FAIL b2b_ack_width idx=%0d ack1=%b required 0", k, ack1); end
    end
    repeat (10) @(negedge clock);
    checks++;
    if (acks_seen - base != 3) begin errors++; $display("FAIL b2b_count acks=%0d required 3", acks_seen - base); end
  endtask
  task automatic test_timeout;
    logic got, idl, fw;
    int cyc;
    stall = 1;
    sb.push_back(exp_t'({1'b0, 8'h00, 1'b1}));
    run_req(0, 0, 5'd4, 8'h00, got, idl, fw, cyc);
    checks++;
    if (!got || cyc < 64 || cyc > 67) begin errors++; $display("FAIL timeout_latency acked=%b cycles=%0d required 1 within 64..67", got, cyc); end
    checks++;
    if ({busy, mem_address, mem_wren} !== {1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_settle busy=%b addr=%h wren=%b required 1 00 0", busy, mem_address, mem_wren);
    end
    stall = 0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL settle_exit busy=%b required 0", busy); end
  endtask
  task automatic test_reset_mid;
    logic got, idl, fw;
    int cyc;
    int base = acks_seen;
    lat = 10;
    @(posedge clock); #1;
    req0 = 1; we0 = 1; addr0 = 5'd9; wdata0 = 8'h77;
    repeat (5) @(posedge clock);
    #1 reset = 1; req0 = 0; we0 = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clock);
    checks++;
    if (acks_seen != base || busy !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_write acks=%0d busy=%b required 0 0", acks_seen - base, busy);
    end
    lat = 0;
    sb.push_back(exp_t'({1'b0, 8'h05, 1'b0}));
    run_req(0, 0, 5'd0, 8'h00, got, idl, fw, cyc);
    checks++;
    if (!got) begin errors++; $display("FAIL read_after_reset acked=0 required 1"); end
  endtask
  initial begin
    test_reset();
    test_dual();
    test_repeat_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain pending=%0d required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
